// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN layer blocks.
//   FM_SINT / FM_HALF : FLOAT_MODE encodings (signed integer / IEEE-754 half)
//   pool_state_e      : pooling FSM states
//   clogMin1          : $clog2 that never returns zero, for counter widths
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int FM_SINT = 0;
  localparam int FM_HALF = 1;

  typedef enum logic {
    IDLE,
    SCAN
  } pool_state_e;

  // A counter that only ever holds 0 still needs one bit to exist.
  function automatic int clogMin1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_max_cmp.sv
// ---------------------------------------------------------------------------
// pool_max_cmp
// Combinational max(a, b) for pooling stages. Ties return a, so the running
// accumulator is kept when a new element only equals it.
// Ports:
//   a_i   : DATA_WIDTH  running maximum (accumulator)
//   b_i   : DATA_WIDTH  candidate element
//   max_o : DATA_WIDTH  the larger of the two, a on a tie
// Parameters:
//   DATA_WIDTH : element width
//   FLOAT_MODE : FM_SINT signed compare, FM_HALF sign/magnitude half compare
// ---------------------------------------------------------------------------
module pool_max_cmp
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FLOAT_MODE = FM_SINT
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] max_o
);

  logic bWins;

  generate
    if (FLOAT_MODE == FM_HALF) begin : g_half
      logic                  signA;
      logic                  signB;
      logic [DATA_WIDTH-2:0] magA;
      logic [DATA_WIDTH-2:0] magB;

      assign signA = a_i[DATA_WIDTH-1];
      assign signB = b_i[DATA_WIDTH-1];
      assign magA  = a_i[DATA_WIDTH-2:0];
      assign magB  = b_i[DATA_WIDTH-2:0];

      // Sign/magnitude ordering. Both zeros (either sign) compare equal, so
      // +0/-0 never displace each other; NaN/Inf are ordered by bits only.
      always_comb begin
        bWins = 1'b0;
        if (magA == '0 && magB == '0) begin
          bWins = 1'b0;
        end else if (signA != signB) begin
          bWins = signA;
        end else if (!signA) begin
          bWins = (magB > magA);
        end else begin
          bWins = (magB < magA);
        end
      end
    end else begin : g_sint
      assign bWins = ($signed(b_i) > $signed(a_i));
    end
  endgenerate

  assign max_o = bWins ? b_i : a_i;

endmodule

// File: rtl/max_pool_layer_single.sv
// ---------------------------------------------------------------------------
// max_pool_layer_single
// PxP, stride-P max pooling over one flattened HxW feature map, one window
// element per clock. The map is captured on start so the upstream bus is
// free to change afterwards.
// Ports:
//   clk   : clock, posedge
//   rst   : synchronous active-high reset, wins over start
//   start : single-cycle request, accepted only in IDLE
//   img   : H*W*DATA_WIDTH input map, element (r,c) at index
//           (H*W-1)-(r*W+c), so the top-left element sits in the MSBs
//   busy  : high from the capture edge until the final write
//   done  : sticky result-valid, cleared by an accepted start or rst
//   res   : (H/P)*(W/P)*DATA_WIDTH pooled map, same packing as img
// Build option:
//   POOL_RELU_EN : when defined, negative window maxima are written as 0
// ---------------------------------------------------------------------------
module max_pool_layer_single
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FLOAT_MODE = FM_SINT,
  parameter int H          = 4,
  parameter int W          = 4,
  parameter int P          = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [H*W*DATA_WIDTH-1:0]             img,
  output logic                                  busy,
  output logic                                  done,
  output logic [(H/P)*(W/P)*DATA_WIDTH-1:0]     res
);

  localparam int OH   = H / P;
  localparam int OW   = W / P;
  localparam int NIN  = H * W;
  localparam int NOUT = OH * OW;
  localparam int KW   = clogMin1(P);
  localparam int OHW  = clogMin1(OH);
  localparam int OWW  = clogMin1(OW);
  localparam int IDXW = clogMin1(NIN);
  localparam int SLW  = clogMin1(NOUT);

  localparam logic [KW-1:0]  K_LAST  = KW'(P - 1);
  localparam logic [OHW-1:0] WR_LAST = OHW'(OH - 1);
  localparam logic [OWW-1:0] WC_LAST = OWW'(OW - 1);

  pool_state_e             state_q, state_d;
  logic [NIN*DATA_WIDTH-1:0] map_q, map_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [KW-1:0]           kr_q, kr_d, kc_q, kc_d;
  logic [OHW-1:0]          wr_q, wr_d;
  logic [OWW-1:0]          wc_q, wc_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   res_q [NOUT];
  logic [DATA_WIDTH-1:0]   res_d [NOUT];

  logic [DATA_WIDTH-1:0]   mapElem [NIN];
  logic [IDXW-1:0]         elemIdx;
  logic [SLW-1:0]          slotIdx;
  logic [DATA_WIDTH-1:0]   elem;
  logic [DATA_WIDTH-1:0]   cmpMax;
  logic [DATA_WIDTH-1:0]   winMax;
  logic [DATA_WIDTH-1:0]   writeVal;

  // mapElem[r*W+c] is element (r,c); res packs slot s the same way.
  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : g_unpack
      assign mapElem[gi] = map_q[(NIN-1-gi)*DATA_WIDTH +: DATA_WIDTH];
    end
    for (gi = 0; gi < NOUT; gi++) begin : g_pack
      assign res[(NOUT-1-gi)*DATA_WIDTH +: DATA_WIDTH] = res_q[gi];
    end
  endgenerate

  always_comb begin
    elemIdx = IDXW'((int'(wr_q) * P + int'(kr_q)) * W + int'(wc_q) * P + int'(kc_q));
    slotIdx = SLW'(int'(wr_q) * OW + int'(wc_q));
  end

  assign elem = mapElem[elemIdx];

  pool_max_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .FLOAT_MODE (FLOAT_MODE)
  ) u_cmp (
    .a_i   (acc_q),
    .b_i   (elem),
    .max_o (cmpMax)
  );

  // The first element of a window restarts the accumulator, which also
  // makes P=1 write the element straight through.
  assign winMax = (kr_q == '0 && kc_q == '0) ? elem : cmpMax;

`ifdef POOL_RELU_EN
  assign writeVal = winMax[DATA_WIDTH-1] ? '0 : winMax;
`else
  assign writeVal = winMax;
`endif

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    acc_d   = acc_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    wr_d    = wr_q;
    wc_d    = wc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          map_d   = img;
          acc_d   = '0;
          kr_d    = '0;
          kc_d    = '0;
          wr_d    = '0;
          wc_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        acc_d = winMax;
        if (kc_q == K_LAST) begin
          kc_d = '0;
          kr_d = (kr_q == K_LAST) ? '0 : kr_q + 1'b1;
        end else begin
          kc_d = kc_q + 1'b1;
        end

        // Last element of the window: commit and step to the next window.
        if (kr_q == K_LAST && kc_q == K_LAST) begin
          res_d[slotIdx] = writeVal;
          if (wc_q == WC_LAST) begin
            wc_d = '0;
            if (wr_q == WR_LAST) begin
              wr_d    = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              wr_d = wr_q + 1'b1;
            end
          end else begin
            wc_d = wc_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      map_q   <= '0;
      acc_q   <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      wr_q    <= '0;
      wc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NOUT; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      acc_q   <= acc_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_max_pool_layer_single.sv
// ---------------------------------------------------------------------------
// tb_max_pool_layer_single
// Directed bench for max_pool_layer_single: an integer instance and a
// half-float instance, both 4x4 maps with 2x2 pooling. Expected maps are
// worked out by hand below; POOL_RELU_EN selects the ReLU'd expectations.
// ---------------------------------------------------------------------------
module tb_max_pool_layer_single;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          startF;
  logic [255:0]  img;
  logic [255:0]  imgF;
  logic          busy, done, busyF, doneF;
  logic [63:0]   res, resF;

  int nAssert = 0;
  int nFail   = 0;
  int edges;
  int busyCnt;

  localparam logic [255:0] MAP1 = {16'd1,  16'd2,  16'd3,  16'd4,
                                   16'd5,  16'd6,  16'd7,  16'd8,
                                   16'd9,  16'd10, 16'd11, 16'd12,
                                   16'd13, 16'd14, 16'd15, 16'd16};
  localparam logic [63:0]  EXP1 = {16'd6, 16'd8, 16'd14, 16'd16};

  // Top-left window {-3,-7,-1,-9}, everything else positive.
  localparam logic [255:0] MAPN = {16'hFFFD, 16'hFFF9, 16'd3,  16'd4,
                                   16'hFFFF, 16'hFFF7, 16'd7,  16'd8,
                                   16'd9,    16'd10,   16'd11, 16'd12,
                                   16'd13,   16'd14,   16'd15, 16'd16};

  // Windows: {1,-1,2,0.5} {-1,-2,-0.5,-4} {-0,+0,+0,-0} {1,2,2,1}
  localparam logic [255:0] MAPF = {16'h3C00, 16'hBC00, 16'hBC00, 16'hC000,
                                   16'h4000, 16'h3800, 16'hB800, 16'hC400,
                                   16'h8000, 16'h0000, 16'h3C00, 16'h4000,
                                   16'h0000, 16'h8000, 16'h4000, 16'h3C00};

`ifdef POOL_RELU_EN
  localparam logic [15:0] NEG_SLOT = 16'h0000;
  localparam logic [15:0] F_SLOT1  = 16'h0000;
  localparam logic [15:0] F_SLOT2  = 16'h0000;
`else
  localparam logic [15:0] NEG_SLOT = 16'hFFFF;
  localparam logic [15:0] F_SLOT1  = 16'hB800;
  localparam logic [15:0] F_SLOT2  = 16'h8000;
`endif
  localparam logic [63:0] EXPN = {NEG_SLOT, 16'd8, 16'd14, 16'd16};
  localparam logic [63:0] EXPF = {16'h4000, F_SLOT1, F_SLOT2, 16'h4000};

  always #5 clk = ~clk;

  max_pool_layer_single #(
    .DATA_WIDTH (16), .FLOAT_MODE (0), .H (4), .W (4), .P (2)
  ) dutI (
    .clk (clk), .rst (rst), .start (start), .img (img),
    .busy (busy), .done (done), .res (res)
  );

  max_pool_layer_single #(
    .DATA_WIDTH (16), .FLOAT_MODE (1), .H (4), .W (4), .P (2)
  ) dutF (
    .clk (clk), .rst (rst), .start (startF), .img (imgF),
    .busy (busyF), .done (doneF), .res (resF)
  );

  // One comparison: count it, and report tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nAssert++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start with mapVal and run to done. The img bus is scrambled after
  // the capture edge; when injectAt is reached a second start with injImg is
  // raised so the following edge sees it while the FSM is still scanning.
  task automatic applyStimulus(input logic [255:0] mapVal, input int injectAt,
                               input logic [255:0] injImg,
                               output int nEdges, output int nBusy);
    @(negedge clk);
    img   = mapVal;
    start = 1'b1;
    @(posedge clk);
    #1;
    nEdges = 1;
    nBusy  = busy ? 1 : 0;
    checkOutput("startBusy", {63'd0, busy}, 64'd1);
    checkOutput("startDoneClr", {63'd0, done}, 64'd0);
    while (!done && nEdges < 100) begin
      @(negedge clk);
      start = 1'b0;
      img   = ~mapVal;
      if (nEdges == injectAt) begin
        start = 1'b1;
        img   = injImg;
      end
      @(posedge clk);
      #1;
      nEdges++;
      if (busy) nBusy++;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("doneInBudget", {63'd0, done}, 64'd1);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    startF = 1'b0;
    img    = '0;
    imgF   = '0;

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", {63'd0, busy}, 64'd0);
    checkOutput("rstDone", {63'd0, done}, 64'd0);
    checkOutput("rstRes", res, 64'd0);
    checkOutput("rstBusyF", {63'd0, busyF}, 64'd0);
    checkOutput("rstDoneF", {63'd0, doneF}, 64'd0);
    checkOutput("rstResF", resF, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ascending map, img scrambled right after capture.
    applyStimulus(MAP1, 0, '0, edges, busyCnt);
    checkOutput("map1Latency", 64'(edges), 64'd17);
    checkOutput("map1BusyCycles", 64'(busyCnt), 64'd16);
    checkOutput("map1Res", res, EXP1);
    checkOutput("map1BusyEnd", {63'd0, busy}, 64'd0);

    // done and res hold while idle.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stickyDone", {63'd0, done}, 64'd1);
    checkOutput("holdRes", res, EXP1);

    // Negative window, with a start at SCAN cycle 5 that must be ignored.
    applyStimulus(MAPN, 5, MAP1, edges, busyCnt);
    checkOutput("negLatency", 64'(edges), 64'd17);
    checkOutput("negRes", res, EXPN);

    // Start coinciding with the final write is dropped.
    applyStimulus(MAP1, 16, MAPN, edges, busyCnt);
    checkOutput("lastLatency", 64'(edges), 64'd17);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("lastStartIgnored", {63'd0, busy}, 64'd0);
    checkOutput("lastRes", res, EXP1);

    // Reset in the middle of a scan.
    @(negedge clk);
    img   = MAPN;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midRstBusy", {63'd0, busy}, 64'd0);
    checkOutput("midRstDone", {63'd0, done}, 64'd0);
    checkOutput("midRstRes", res, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(MAP1, 0, '0, edges, busyCnt);
    checkOutput("postRstLatency", 64'(edges), 64'd17);
    checkOutput("postRstRes", res, EXP1);

    // Half-float instance.
    @(negedge clk);
    imgF   = MAPF;
    startF = 1'b1;
    @(posedge clk);
    #1;
    edges = 1;
    @(negedge clk);
    startF = 1'b0;
    imgF   = '0;
    while (!doneF && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("floatDone", {63'd0, doneF}, 64'd1);
    checkOutput("floatLatency", 64'(edges), 64'd17);
    checkOutput("floatRes", resF, EXPF);
    checkOutput("floatBusyEnd", {63'd0, busyF}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
